// File: rtl/and_ff_arb_pkg.sv
// Shared types and helpers for the and_ff round-robin arbiter.
// Imported by the picker and the top-level controller.
package and_ff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int NUM_REQ_DEF = 4;

    // Index width for a requester count, at least one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_w(NUM_REQ_DEF);

endpackage

// File: rtl/and_ff_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_pick
    import and_ff_arb_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int IW = idx_w(NUM_REQ_DEF)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_oh,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_k;

    // Scan from the pointer, keep the first hit.
    always_comb begin
        o_oh  = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_k   = '0;
        for (int i = 0; i < N; i++) begin
            w_k = IW'((int'(i_ptr) + i) % N);
            if (!o_any && i_req[w_k]) begin
                o_any      = 1'b1;
                o_idx      = w_k;
                o_oh[w_k]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/and_ff_arbiter.sv
// Shares one registered AND unit among NUM_REQ requesters,
// one transaction at a time, with round-robin fairness.
module and_ff_arbiter
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_a,
    input  logic [NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic               rsp_z,
    output logic               busy,
    output logic               ff_enable,
    output logic               ff_a,
    output logic               ff_b,
    input  logic               ff_z,
    output logic [CNT_W-1:0]   done_cnt
);
    import and_ff_arb_pkg::*;

    localparam int IW = idx_w(NUM_REQ);

    state_t             r_state;
    logic [IW-1:0]      r_ptr;
    logic [NUM_REQ-1:0] r_sel;
    logic               r_ff_en;
    logic               r_ff_a;
    logic               r_ff_b;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic               r_rsp_z;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_oh;
    logic [IW-1:0]      w_idx;
    logic               w_any;
    logic [IW-1:0]      w_ptr_nxt;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_oh  (w_oh),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Pointer moves just past the winner, wrapping at the top.
    assign w_ptr_nxt = (w_idx == IW'(NUM_REQ - 1)) ?
                       '0 : w_idx + IW'(1);

    // Grant only in IDLE and never while reset is asserted.
    assign gnt = (!rst && r_state == IDLE) ? w_oh : '0;

    assign busy      = (r_state != IDLE);
    assign ff_enable = r_ff_en;
    assign ff_a      = r_ff_a;
    assign ff_b      = r_ff_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_z     = r_rsp_z;
    assign done_cnt  = r_cnt;

    // Transaction FSM, operand issue, response capture, counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_ff_en     <= 1'b0;
            r_ff_a      <= 1'b0;
            r_ff_b      <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_z     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_rsp_valid <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_oh;
                        r_ff_a  <= req_a[w_idx];
                        r_ff_b  <= req_b[w_idx];
                        r_ff_en <= 1'b1;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_ff_en <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_rsp_z     <= ff_z;
                    r_rsp_valid <= r_sel;
                    if (r_cnt != '1)
                        r_cnt <= r_cnt + CNT_W'(1);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
